data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the shared data bus: the endpoint that answers DataMem_Read/DataMem_Write requests forwarded by the bus from the granted core.
- Holds a single-port word-addressed RAM and inserts a programmable number of wait states.
- Returns read data with a one-cycle DataMem_Ready pulse and applies byte-enabled writes.
- Used as the data memory model/controller in multicore builds and benches.

Parameters:
- ADDR_WIDTH, 10: number of implemented word-address bits; RAM depth is 2**ADDR_WIDTH words.
- WAIT_STATES, 2: cycles spent in WAIT before the ack cycle; legal range 0..15.
- CNT_WIDTH, 16: width of the saturating transaction counters.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- DataMem_Read  in  1  read request, held by requester until Ready
- DataMem_Write  in  4  byte-lane write enables; [3]=bits 31:24 ... [0]=bits 7:0; nonzero = write request
- DataMem_Address  in  30  word address
- DataMem_Out  in  32  write data from bus
- DataMem_In  out  32  read data to bus
- DataMem_Ready  out  1  one-cycle completion pulse
- Busy  out  1  high while a transaction is in progress (WAIT or ACK)
- AddrErr  out  1  one-cycle pulse, coincident with Ready, when the completed access was out of range
- RdCount  out  CNT_WIDTH  completed reads, saturating
- WrCount  out  CNT_WIDTH  completed writes, saturating

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high, port `reset`. Reset has priority over everything.
- Reset values: DataMem_In=0, DataMem_Ready=0, Busy=0, AddrErr=0, RdCount=0, WrCount=0, FSM=IDLE. RAM contents are not reset.
- Request definition: req = DataMem_Read | (DataMem_Write != 0).
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if req, latch address, write data, byte enables and op.
    - Write op if any Write bit is set (write wins over a simultaneous Read). Otherwise read.
    - Load the wait counter with WAIT_STATES.
    - Go to WAIT if WAIT_STATES>0, else go to ACK.
  - WAIT: decrement the counter; on the edge where it reaches 0, go to ACK.
  - ACK: DataMem_Ready=1 for exactly this cycle; next state is IDLE.
- Latency: request sampled in IDLE at edge t gives Ready high in cycle t+1+WAIT_STATES.
- Back-to-back: the IDLE cycle after ACK samples req again. A request still held is treated as a new transaction, giving a minimum spacing of WAIT_STATES+2 cycles between Ready pulses.
- Latched operands: changes to Address/Out/Write/Read after acceptance are ignored.
- Request dropped mid-transaction: the transaction still completes, Ready still pulses and the write is still committed.
- RAM access on the edge entering ACK:
  - Read: DataMem_In <= RAM[addr].
  - Write: only enabled lanes updated; DataMem_In <= pre-write word (read-before-write).
- DataMem_In holds its value until the next ACK; it is valid only when Ready=1.
- Range check: out of range when latched address bits [29:ADDR_WIDTH] != 0.
  - Write is dropped; DataMem_In <= 0.
  - AddrErr pulses with Ready; the counters still increment.
- Counters:
  - RdCount increments on ACK of a read; WrCount increments on ACK of a write.
  - Both saturate at all-ones, with no wrap.
- Reset mid-transaction (in WAIT, or on the edge that would enter ACK): transaction aborted, no RAM write, no Ready pulse, outputs at reset values next cycle.
- Busy = (state != IDLE).

Test Plan:
- Write then read, WAIT_STATES=2: write addr 0x5, data 0xDEADBEEF, Write=4'hF asserted at edge 0 -> Ready only in cycle 3, WrCount=1; read addr 0x5 -> Ready 3 cycles after acceptance, DataMem_In=0xDEADBEEF, RdCount=1.
- Byte lanes: word 0x5 = 0xDEADBEEF; write 0x11223344 with Write=4'b0101 -> DataMem_In=0xDEADBEEF on that ack; subsequent read returns 0xDE22BE44.
- Out of range, ADDR_WIDTH=10: read addr 0x400 -> Ready with AddrErr=1, DataMem_In=0; write 0xFFFFFFFF to 0x400 then read 0x0 -> original word unchanged.
- Held request / back-to-back: Read held high continuously for addresses 1 then 2 -> Ready pulses exactly 4 cycles apart (WAIT_STATES=2), each pulse one cycle wide, data matching each address.
- Reset mid-op: write 0xCAFEF00D to addr 7 accepted, reset asserted one cycle later for one cycle -> no Ready, Busy=0 after reset; read addr 7 returns the prior contents.
- WAIT_STATES=0 and saturation (CNT_WIDTH=4): single read -> Ready in the cycle after acceptance; 20 reads -> RdCount holds 15.

Source files
------------

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : Shared data-bus bundle between the bus (master) and the data
//            memory responder (slave), including responder status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 DataMem_Read;
    logic [3:0]           DataMem_Write;
    logic [29:0]          DataMem_Address;
    logic [31:0]          DataMem_Out;
    logic [31:0]          DataMem_In;
    logic                 DataMem_Ready;
    logic                 Busy;
    logic                 AddrErr;
    logic [CNT_WIDTH-1:0] RdCount;
    logic [CNT_WIDTH-1:0] WrCount;

    modport master (
        output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
        input  DataMem_In, DataMem_Ready, Busy, AddrErr, RdCount, WrCount
    );

    modport slave (
        input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
        output DataMem_In, DataMem_Ready, Busy, AddrErr, RdCount, WrCount
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Word-addressed single-port data RAM answering bus read/write
//            requests after a programmable number of wait states.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  wire logic                clock,
    input  wire logic                reset,
    data_mem_responder_if.slave      bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_ACK    = 2'd2;
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);
    localparam int         c_DEPTH     = 1 << ADDR_WIDTH;

    logic [1:0]           r_state_q,    w_state_d;
    logic [3:0]           r_wcnt_q,     w_wcnt_d;
    logic [29:0]          r_addr_q,     w_addr_d;
    logic [31:0]          r_wdata_q,    w_wdata_d;
    logic [3:0]           r_be_q,       w_be_d;
    logic                 r_is_wr_q,    w_is_wr_d;
    logic [31:0]          r_rdata_q,    w_rdata_d;
    logic                 r_addr_err_q, w_addr_err_d;
    logic [CNT_WIDTH-1:0] r_rd_cnt_q,   w_rd_cnt_d;
    logic [CNT_WIDTH-1:0] r_wr_cnt_q,   w_wr_cnt_d;

    logic [31:0]          r_mem [c_DEPTH];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_enter_ack;
    logic                  w_sel_bus;
    logic [29:0]           w_op_addr;
    logic [31:0]           w_op_wdata;
    logic [3:0]            w_op_be;
    logic                  w_op_is_wr;
    logic                  w_op_oor;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [31:0]           w_mem_word;
    logic                  w_mem_we;

    assign w_req       = bus.DataMem_Read | (|bus.DataMem_Write);
    assign w_accept    = (r_state_q == c_ST_IDLE) & w_req;
    assign w_enter_ack = (w_state_d == c_ST_ACK) & (r_state_q != c_ST_ACK);

    // With zero wait states the RAM is accessed on the accepting edge, so the
    // operands come straight from the bus rather than from the latches.
    assign w_sel_bus  = (r_state_q == c_ST_IDLE);
    assign w_op_addr  = w_sel_bus ? bus.DataMem_Address : r_addr_q;
    assign w_op_wdata = w_sel_bus ? bus.DataMem_Out     : r_wdata_q;
    assign w_op_be    = w_sel_bus ? bus.DataMem_Write   : r_be_q;
    assign w_op_is_wr = w_sel_bus ? (|bus.DataMem_Write) : r_is_wr_q;
    assign w_idx      = w_op_addr[ADDR_WIDTH-1:0];
    assign w_mem_word = r_mem[w_idx];

    generate
        if (ADDR_WIDTH < 30) begin : g_range_chk
            assign w_op_oor = |w_op_addr[29:ADDR_WIDTH];
        end else begin : g_range_full
            assign w_op_oor = 1'b0;
        end
    endgenerate

    assign w_mem_we = w_enter_ack & w_op_is_wr & ~w_op_oor & ~reset;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_IDLE: begin
                if (w_req) begin
                    w_state_d = (c_WAIT_LOAD == 4'd0) ? c_ST_ACK : c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (r_wcnt_q == 4'd1) begin
                    w_state_d = c_ST_ACK;
                end
            end
            c_ST_ACK:  w_state_d = c_ST_IDLE;
            default:   w_state_d = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.DataMem_Ready = (r_state_q == c_ST_ACK);
        bus.Busy          = (r_state_q != c_ST_IDLE);
        bus.AddrErr       = (r_state_q == c_ST_ACK) & r_addr_err_q;
        bus.DataMem_In    = r_rdata_q;
        bus.RdCount       = r_rd_cnt_q;
        bus.WrCount       = r_wr_cnt_q;
    end

    always_comb begin
        w_wcnt_d     = r_wcnt_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_be_d       = r_be_q;
        w_is_wr_d    = r_is_wr_q;
        w_rdata_d    = r_rdata_q;
        w_addr_err_d = r_addr_err_q;
        w_rd_cnt_d   = r_rd_cnt_q;
        w_wr_cnt_d   = r_wr_cnt_q;

        if (w_accept) begin
            w_addr_d  = bus.DataMem_Address;
            w_wdata_d = bus.DataMem_Out;
            w_be_d    = bus.DataMem_Write;
            w_is_wr_d = |bus.DataMem_Write;
            w_wcnt_d  = c_WAIT_LOAD;
        end else if (r_state_q == c_ST_WAIT) begin
            w_wcnt_d  = r_wcnt_q - 4'd1;
        end

        // Writes also return the pre-write word; out-of-range returns zero.
        if (w_enter_ack) begin
            w_rdata_d    = w_op_oor ? 32'd0 : w_mem_word;
            w_addr_err_d = w_op_oor;
            if (w_op_is_wr) begin
                if (r_wr_cnt_q != '1) w_wr_cnt_d = r_wr_cnt_q + CNT_WIDTH'(1);
            end else begin
                if (r_rd_cnt_q != '1) w_rd_cnt_d = r_rd_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wcnt_q     <= 4'd0;
            r_addr_q     <= 30'd0;
            r_wdata_q    <= 32'd0;
            r_be_q       <= 4'd0;
            r_is_wr_q    <= 1'b0;
            r_rdata_q    <= 32'd0;
            r_addr_err_q <= 1'b0;
            r_rd_cnt_q   <= '0;
            r_wr_cnt_q   <= '0;
        end else begin
            r_wcnt_q     <= w_wcnt_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_be_q       <= w_be_d;
            r_is_wr_q    <= w_is_wr_d;
            r_rdata_q    <= w_rdata_d;
            r_addr_err_q <= w_addr_err_d;
            r_rd_cnt_q   <= w_rd_cnt_d;
            r_wr_cnt_q   <= w_wr_cnt_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_op_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_op_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Bench for data_mem_responder: directed scenarios plus randomized
//            traffic against a word/byte-lane memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic clock = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   exp_rd_a = 0;
    int   exp_wr_a = 0;
    int   exp_rd_b = 0;
    int   exp_wr_b = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    data_mem_responder_if #(.CNT_WIDTH(16)) ifa ();
    data_mem_responder_if #(.CNT_WIDTH(4))  ifb ();

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .CNT_WIDTH(16)) dut_a (
        .clock (clock),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .CNT_WIDTH(4)) dut_b (
        .clock (clock),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    function automatic logic get_ready(input bit sel);
        return sel ? ifb.DataMem_Ready : ifa.DataMem_Ready;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? ifb.Busy : ifa.Busy;
    endfunction
    function automatic logic get_aerr(input bit sel);
        return sel ? ifb.AddrErr : ifa.AddrErr;
    endfunction
    function automatic logic [31:0] get_in(input bit sel);
        return sel ? ifb.DataMem_In : ifa.DataMem_In;
    endfunction

    // Byte-lane merge as seen from the bus: enabled lanes take the new data.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic drive(input bit sel, input logic rd, input logic [3:0] we,
                         input logic [29:0] addr, input logic [31:0] wd);
        if (sel) begin
            ifb.DataMem_Read = rd; ifb.DataMem_Write = we;
            ifb.DataMem_Address = addr; ifb.DataMem_Out = wd;
        end else begin
            ifa.DataMem_Read = rd; ifa.DataMem_Write = we;
            ifa.DataMem_Address = addr; ifa.DataMem_Out = wd;
        end
    endtask

    // One request, dropped and scrambled right after acceptance. Called at a
    // negedge with the DUT idle; returns at a negedge with the DUT idle.
    // lat counts negedges from acceptance to Ready (-1 on timeout).
    task automatic txn(input bit sel, input logic rd, input logic [3:0] we,
                       input logic [29:0] addr, input logic [31:0] wd,
                       output logic [31:0] rdata, output logic aerr,
                       output int lat, output bit tail_ok);
        bit got = 1'b0;
        drive(sel, rd, we, addr, wd);
        @(posedge clock);
        lat = 0; rdata = '0; aerr = 1'b0; tail_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            lat++;
            if (i == 0) drive(sel, 1'b0, 4'h0, 30'($urandom), $urandom);
            if (get_ready(sel)) begin
                got = 1'b1; rdata = get_in(sel); aerr = get_aerr(sel);
                break;
            end
        end
        if (!got) begin
            lat = -1;
        end else begin
            @(negedge clock);
            tail_ok = !get_ready(sel) && !get_busy(sel);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 4'h0, 30'd0, 32'd0);
        drive(1, 1'b0, 4'h0, 30'd0, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clock);
        n_checks++; if (ifa.DataMem_In !== 32'd0) $display("FAIL reset_in: got %h expected 0", ifa.DataMem_In); else n_pass++;
        n_checks++; if (ifa.DataMem_Ready !== 1'b0 || ifa.AddrErr !== 1'b0) $display("FAIL reset_ready_aerr: got %b%b expected 00", ifa.DataMem_Ready, ifa.AddrErr); else n_pass++;
        n_checks++; if (ifa.Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", ifa.Busy); else n_pass++;
        n_checks++; if (ifa.RdCount !== 16'd0 || ifa.WrCount !== 16'd0) $display("FAIL reset_counts: got %0d/%0d expected 0/0", ifa.RdCount, ifa.WrCount); else n_pass++;
        n_checks++; if (ifb.DataMem_Ready !== 1'b0 || ifb.Busy !== 1'b0 || ifb.RdCount !== 4'd0) $display("FAIL reset_b: got rdy=%b busy=%b rd=%0d expected 0 0 0", ifb.DataMem_Ready, ifb.Busy, ifb.RdCount); else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic ae; int lat; bit tl;
        txn(0, 1'b0, 4'hF, 30'h5, 32'hDEADBEEF, rd, ae, lat, tl); exp_wr_a++;
        n_checks++; if (lat !== 3) $display("FAIL wr_latency: got %0d expected 3", lat); else n_pass++;
        n_checks++; if (tl !== 1'b1) $display("FAIL wr_pulse_width: got %b expected 1", tl); else n_pass++;
        n_checks++; if (ifa.WrCount !== 16'(exp_wr_a)) $display("FAIL wr_count: got %0d expected %0d", ifa.WrCount, exp_wr_a); else n_pass++;
        txn(0, 1'b1, 4'h0, 30'h5, 32'h0, rd, ae, lat, tl); exp_rd_a++;
        n_checks++; if (lat !== 3) $display("FAIL rd_latency: got %0d expected 3", lat); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF || ae !== 1'b0) $display("FAIL rd_data: got %h aerr=%b expected deadbeef aerr=0", rd, ae); else n_pass++;
        n_checks++; if (ifa.RdCount !== 16'(exp_rd_a)) $display("FAIL rd_count: got %0d expected %0d", ifa.RdCount, exp_rd_a); else n_pass++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic ae; int lat; bit tl;
        txn(0, 1'b0, 4'b0101, 30'h5, 32'h11223344, rd, ae, lat, tl); exp_wr_a++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lane_prewrite: got %h expected deadbeef", rd); else n_pass++;
        txn(0, 1'b1, 4'h0, 30'h5, 32'h0, rd, ae, lat, tl); exp_rd_a++;
        n_checks++; if (rd !== 32'hDE22BE44) $display("FAIL lane_merge: got %h expected de22be44", rd); else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic ae; int lat; bit tl;
        txn(0, 1'b0, 4'hF, 30'h0, 32'h0BADCAFE, rd, ae, lat, tl); exp_wr_a++;
        txn(0, 1'b1, 4'h0, 30'h400, 32'h0, rd, ae, lat, tl); exp_rd_a++;
        n_checks++; if (ae !== 1'b1 || rd !== 32'd0 || lat !== 3) $display("FAIL oor_read: got aerr=%b data=%h lat=%0d expected 1 0 3", ae, rd, lat); else n_pass++;
        txn(0, 1'b0, 4'hF, 30'h400, 32'hFFFFFFFF, rd, ae, lat, tl); exp_wr_a++;
        n_checks++; if (ae !== 1'b1 || rd !== 32'd0) $display("FAIL oor_write: got aerr=%b data=%h expected 1 0", ae, rd); else n_pass++;
        n_checks++; if (ifa.WrCount !== 16'(exp_wr_a) || ifa.RdCount !== 16'(exp_rd_a)) $display("FAIL oor_counts: got %0d/%0d expected %0d/%0d", ifa.RdCount, ifa.WrCount, exp_rd_a, exp_wr_a); else n_pass++;
        txn(0, 1'b1, 4'h0, 30'h0, 32'h0, rd, ae, lat, tl); exp_rd_a++;
        n_checks++; if (rd !== 32'h0BADCAFE || ae !== 1'b0) $display("FAIL oor_no_alias: got %h aerr=%b expected 0badcafe 0", rd, ae); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, v1, v2, d1, d2; logic ae; int lat; bit tl;
        int t1 = -1; int t2 = -1; bit wide = 1'b0; logic prev = 1'b0;
        v1 = $urandom; v2 = $urandom;
        txn(0, 1'b0, 4'hF, 30'h1, v1, rd, ae, lat, tl); exp_wr_a++;
        txn(0, 1'b0, 4'hF, 30'h2, v2, rd, ae, lat, tl); exp_wr_a++;
        d1 = '0; d2 = '0;
        drive(0, 1'b1, 4'h0, 30'h1, 32'h0);
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            @(negedge clock);
            if (prev && ifa.DataMem_Ready) wide = 1'b1;
            prev = ifa.DataMem_Ready;
            if (ifa.DataMem_Ready && !wide) begin
                if (t1 < 0) begin
                    t1 = cyc; d1 = ifa.DataMem_In; ifa.DataMem_Address = 30'h2;
                end else begin
                    t2 = cyc; d2 = ifa.DataMem_In; drive(0, 1'b0, 4'h0, 30'h0, 32'h0);
                end
            end
        end
        @(negedge clock);
        if (ifa.DataMem_Ready) wide = 1'b1;
        exp_rd_a += 2;
        n_checks++; if (t1 < 0 || t2 < 0 || (t2 - t1) != 4) $display("FAIL b2b_spacing: got t1=%0d t2=%0d expected spacing 4", t1, t2); else n_pass++;
        n_checks++; if (wide !== 1'b0) $display("FAIL b2b_width: got wide=%b expected 0", wide); else n_pass++;
        n_checks++; if (d1 !== v1 || d2 !== v2) $display("FAIL b2b_data: got %h %h expected %h %h", d1, d2, v1, v2); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic ae; int lat; bit tl; bit seen;
        txn(0, 1'b0, 4'hF, 30'h7, 32'h12345678, rd, ae, lat, tl); exp_wr_a++;
        // Reset in the first WAIT cycle
        drive(0, 1'b0, 4'hF, 30'h7, 32'hCAFEF00D);
        @(posedge clock);
        @(negedge clock); drive(0, 1'b0, 4'h0, 30'h0, 32'h0); rst_a = 1'b1;
        @(negedge clock); rst_a = 1'b0;
        exp_rd_a = 0; exp_wr_a = 0;
        n_checks++; if (ifa.Busy !== 1'b0 || ifa.DataMem_Ready !== 1'b0) $display("FAIL rstmid_busy: got busy=%b rdy=%b expected 0 0", ifa.Busy, ifa.DataMem_Ready); else n_pass++;
        n_checks++; if (ifa.WrCount !== 16'd0 || ifa.RdCount !== 16'd0) $display("FAIL rstmid_counts: got %0d/%0d expected 0/0", ifa.RdCount, ifa.WrCount); else n_pass++;
        seen = 1'b0;
        repeat (5) begin @(negedge clock); if (ifa.DataMem_Ready) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) $display("FAIL rstmid_no_ready: got %b expected 0", seen); else n_pass++;
        // Reset coinciding with the edge that would enter ACK
        drive(0, 1'b0, 4'hF, 30'h7, 32'hFEEDFACE);
        @(posedge clock);
        @(negedge clock); drive(0, 1'b0, 4'h0, 30'h0, 32'h0);
        @(negedge clock); rst_a = 1'b1;
        @(negedge clock); rst_a = 1'b0;
        seen = ifa.DataMem_Ready;
        repeat (4) begin @(negedge clock); if (ifa.DataMem_Ready) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0 || ifa.Busy !== 1'b0) $display("FAIL rstack_no_ready: got rdy=%b busy=%b expected 0 0", seen, ifa.Busy); else n_pass++;
        txn(0, 1'b1, 4'h0, 30'h7, 32'h0, rd, ae, lat, tl); exp_rd_a++;
        n_checks++; if (rd !== 32'h12345678) $display("FAIL rstmid_data: got %h expected 12345678", rd); else n_pass++;
        n_checks++; if (ifa.RdCount !== 16'(exp_rd_a)) $display("FAIL rstmid_rdcount: got %0d expected %0d", ifa.RdCount, exp_rd_a); else n_pass++;
    endtask

    task automatic test_random_traffic();
        logic [31:0] ref_mem [16];
        logic [31:0] rd, wd, exp_d; logic ae; int lat; bit tl;
        logic [29:0] addr; logic [3:0] we; bit is_rd, oor;
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = $urandom;
            txn(0, 1'b0, 4'hF, 30'(a), ref_mem[a], rd, ae, lat, tl); exp_wr_a++;
        end
        for (int n = 0; n < 50; n++) begin
            oor   = ($urandom_range(0, 5) == 0);
            is_rd = $urandom_range(0, 1) == 1;
            addr  = oor ? {20'($urandom_range(1, 20'hFFFFF)), 10'($urandom_range(0, 15))}
                        : 30'($urandom_range(0, 15));
            we    = is_rd ? 4'h0 : 4'($urandom_range(1, 15));
            wd    = $urandom;
            // A read that also carries random junk data must not write.
            txn(0, is_rd, we, addr, wd, rd, ae, lat, tl);
            exp_d = oor ? 32'd0 : ref_mem[addr[3:0]];
            if (!is_rd && !oor) ref_mem[addr[3:0]] = merge(ref_mem[addr[3:0]], wd, we);
            if (is_rd) exp_rd_a++; else exp_wr_a++;
            n_checks++; if (rd !== exp_d || ae !== oor || lat !== 3) $display("FAIL rand_txn%0d: got data=%h aerr=%b lat=%0d expected %h %b 3", n, rd, ae, lat, exp_d, oor); else n_pass++;
            n_checks++; if (ifa.RdCount !== 16'(exp_rd_a) || ifa.WrCount !== 16'(exp_wr_a)) $display("FAIL rand_count%0d: got %0d/%0d expected %0d/%0d", n, ifa.RdCount, ifa.WrCount, exp_rd_a, exp_wr_a); else n_pass++;
        end
    endtask

    task automatic test_ws0_saturation();
        logic [31:0] rd, v; logic ae; int lat; bit tl;
        v = $urandom;
        txn(1, 1'b0, 4'hF, 30'h3, v, rd, ae, lat, tl); exp_wr_b++;
        n_checks++; if (lat !== 1 || ifb.WrCount !== 4'(exp_wr_b)) $display("FAIL ws0_write: got lat=%0d wr=%0d expected 1 %0d", lat, ifb.WrCount, exp_wr_b); else n_pass++;
        txn(1, 1'b1, 4'h0, 30'h3, 32'h0, rd, ae, lat, tl); exp_rd_b++;
        n_checks++; if (lat !== 1 || rd !== v || tl !== 1'b1) $display("FAIL ws0_read: got lat=%0d data=%h tail=%b expected 1 %h 1", lat, rd, v, tl); else n_pass++;
        for (int n = 0; n < 20; n++) begin
            txn(1, 1'b1, 4'h0, 30'h3, 32'h0, rd, ae, lat, tl);
            exp_rd_b = (exp_rd_b < 15) ? exp_rd_b + 1 : 15;
            n_checks++; if (ifb.RdCount !== 4'(exp_rd_b)) $display("FAIL ws0_sat%0d: got %0d expected %0d", n, ifb.RdCount, exp_rd_b); else n_pass++;
        end
        n_checks++; if (ifb.RdCount !== 4'd15 || ifb.WrCount !== 4'd1) $display("FAIL ws0_final: got %0d/%0d expected 15/1", ifb.RdCount, ifb.WrCount); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_random_traffic();
        test_ws0_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion (%0d/%0d)", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
